// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, sign fix-up on the last cycle.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             mf_req,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 is_div_q, is_div_d;
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;
   logic                 b_zero_q, b_zero_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;
   logic                 div_zero_q, div_zero_d;

   logic                 signed_op_s;
   logic                 a_neg_s;
   logic                 b_neg_s;
   logic [WIDTH-1:0]     abs_a_s;
   logic [WIDTH-1:0]     abs_b_s;
   logic [WIDTH:0]       mul_sum_s;
   logic [WIDTH:0]       div_shift_s;
   logic                 div_ge_s;
   logic [WIDTH-1:0]     div_diff_s;
   logic [WIDTH-1:0]     rem_next_s;
   logic [2*WIDTH-1:0]   prod_fix_s;
   logic [WIDTH-1:0]     quo_fix_s;
   logic [WIDTH-1:0]     rem_fix_s;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   assign signed_op_s = ~op[0];
   assign a_neg_s     = signed_op_s & a[WIDTH-1];
   assign b_neg_s     = signed_op_s & b[WIDTH-1];
   assign abs_a_s     = a_neg_s ? neg_w(a) : a;
   assign abs_b_s     = b_neg_s ? neg_w(b) : b;

   // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
   assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                      + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
   assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge_s    = (div_shift_s >= {1'b0, opb_q});
   assign div_diff_s  = div_shift_s[WIDTH-1:0] - opb_q;
   assign rem_next_s  = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];

   assign prod_fix_s  = (sign_a_q ^ sign_b_q) ? neg_2w(acc_q) : acc_q;
   assign quo_fix_s   = (sign_a_q ^ sign_b_q) ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
   // With b==0 the remainder path shifts the whole |a| through, so after sign fix it equals a
   assign rem_fix_s   = sign_a_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

   // Next-state, datapath and HI/LO update logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      b_zero_d   = b_zero_q;
      opb_d      = opb_q;
      acc_d      = acc_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
      case (state_q)
         S_IDLE: begin
            if (hi_we) begin
               hi_d = wdata;
            end else begin
               hi_d = hi_q;
            end
            if (lo_we) begin
               lo_d = wdata;
            end else begin
               lo_d = lo_q;
            end
            if (start && !flush) begin
               state_d    = S_CALC;
               cnt_d      = {CNT_W{1'b0}};
               is_div_d   = op[1];
               sign_a_d   = a_neg_s;
               sign_b_d   = b_neg_s;
               b_zero_d   = (b == {WIDTH{1'b0}});
               opb_d      = abs_b_s;
               acc_d      = {{WIDTH{1'b0}}, abs_a_s};
               div_zero_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               if (is_div_q) begin
                  acc_d = {rem_next_s, acc_q[WIDTH-2:0], div_ge_s};
               end else begin
                  acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
               end
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = S_FIX;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (flush) begin
               done_d = 1'b0;
            end else begin
               done_d = 1'b1;
               if (is_div_q) begin
                  lo_d       = b_zero_q ? {WIDTH{1'b1}} : quo_fix_s;
                  hi_d       = rem_fix_s;
                  div_zero_d = b_zero_q;
               end else begin
                  hi_d       = prod_fix_s[2*WIDTH-1:WIDTH];
                  lo_d       = prod_fix_s[WIDTH-1:0];
                  div_zero_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and architectural register update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         is_div_q   <= 1'b0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         b_zero_q   <= 1'b0;
         opb_q      <= {WIDTH{1'b0}};
         acc_q      <= {(2*WIDTH){1'b0}};
         hi_q       <= {WIDTH{1'b0}};
         lo_q       <= {WIDTH{1'b0}};
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         b_zero_q   <= b_zero_d;
         opb_q      <= opb_d;
         acc_q      <= acc_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign stall    = busy & (start | mf_req | hi_we | lo_we);
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a 32-bit and an 8-bit instance, results
// predicted with native arithmetic and compared when done pulses.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start32, start8;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        flush, hi_we, lo_we, mf_req;

   logic        busy32, stall32, done32, dz32;
   logic [31:0] hi32, lo32;
   logic        busy8, stall8, done8, dz8;
   logic [7:0]  hi8, lo8;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t        q32[$];
   exp_t        q8[$];
   exp_t        e32, e8;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_hi, last_lo;
   logic [1:0]  r_op;
   logic [31:0] r_a, r_b;

   always #5 clk = ~clk;

   mult_div_unit #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .op(op), .a(a), .b(b),
      .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .mf_req(mf_req),
      .busy(busy32), .stall(stall32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
   );

   mult_div_unit #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
      .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata[7:0]), .mf_req(mf_req),
      .busy(busy8), .stall(stall8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: native signed/unsigned arithmetic at width w
   function automatic exp_t model(input int w, input logic [1:0] o,
                                  input logic [31:0] aa, input logic [31:0] bb);
      exp_t        e;
      logic [63:0] mask, ua, ub, p;
      longint      sa, sb, q, r;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, aa} & mask;
      ub   = {32'd0, bb} & mask;
      sa   = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
      sb   = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
      e.dz = 1'b0;
      e.hi = 32'd0;
      e.lo = 32'd0;
      case (o)
         2'b00: begin
            p    = 64'(sa * sb);
            e.hi = 32'((p >> w) & mask);
            e.lo = 32'(p & mask);
         end
         2'b01: begin
            p    = ua * ub;
            e.hi = 32'((p >> w) & mask);
            e.lo = 32'(p & mask);
         end
         default: begin
            if (ub == 64'd0) begin
               e.lo = 32'(mask);
               e.hi = 32'(ua);
               e.dz = 1'b1;
            end else if (o == 2'b10) begin
               q    = sa / sb;
               r    = sa % sb;
               e.lo = 32'(64'(q) & mask);
               e.hi = 32'(64'(r) & mask);
            end else begin
               e.lo = 32'((ua / ub) & mask);
               e.hi = 32'((ua % ub) & mask);
            end
         end
      endcase
      return e;
   endfunction

   // 32-bit scoreboard: pop and compare on each done pulse
   always @(negedge clk) begin
      if (rst_n && done32) begin
         if (q32.size() == 0) begin
            check_val("done32_unexpected", 64'd1, 64'd0);
         end else begin
            e32 = q32.pop_front();
            check_val("hi32", 64'(hi32), 64'(e32.hi));
            check_val("lo32", 64'(lo32), 64'(e32.lo));
            check_val("dz32", 64'(dz32), 64'(e32.dz));
            check_val("busy32_in_done", 64'(busy32), 64'd0);
         end
      end
   end

   // 8-bit scoreboard
   always @(negedge clk) begin
      if (rst_n && done8) begin
         if (q8.size() == 0) begin
            check_val("done8_unexpected", 64'd1, 64'd0);
         end else begin
            e8 = q8.pop_front();
            check_val("hi8", 64'(hi8), 64'(e8.hi));
            check_val("lo8", 64'(lo8), 64'(e8.lo));
            check_val("dz8", 64'(dz8), 64'(e8.dz));
         end
      end
   end

   task automatic issue(input bit sel8, input logic [1:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input bit push);
      exp_t e;
      op = o;
      a  = aa;
      b  = bb;
      if (sel8) start8 = 1'b1;
      else      start32 = 1'b1;
      e = model(sel8 ? 8 : 32, o, aa, bb);
      if (push) begin
         if (sel8) q8.push_back(e);
         else begin
            q32.push_back(e);
            last_hi = e.hi;
            last_lo = e.lo;
         end
      end
      @(posedge clk);
      #1;
      start32 = 1'b0;
      start8  = 1'b0;
   endtask

   task automatic wait_done(input bit sel8, input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(sel8 ? done8 : done32) && n < 100);
      check_val({tag, "_latency"}, 64'(n), sel8 ? 64'd9 : 64'd33);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0; op = 2'b00;
      a = 32'd0; b = 32'd0; wdata = 32'd0;
      flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; mf_req = 1'b1;
      #12;
      check_val("rst_busy", 64'(busy32), 64'd0);
      check_val("rst_done", 64'(done32), 64'd0);
      check_val("rst_dz", 64'(dz32), 64'd0);
      check_val("rst_hi", 64'(hi32), 64'd0);
      check_val("rst_lo", 64'(lo32), 64'd0);
      check_val("rst_stall", 64'(stall32), 64'd0);
      mf_req = 1'b0;
      rst_n  = 1'b1;
      @(posedge clk);
      #1;

      issue(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      check_val("busy_after_start", 64'(busy32), 64'd1);
      wait_done(1'b0, "multu_max");
      check_val("busy_done_cycle", 64'(busy32), 64'd0);
      @(posedge clk);
      #1;
      check_val("done_one_cycle", 64'(done32), 64'd0);

      issue(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
      wait_done(1'b0, "mult_neg");
      issue(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done(1'b0, "div_neg");
      issue(1'b0, 2'b11, 32'd100, 32'd0, 1'b1);
      wait_done(1'b0, "divu_zero");
      issue(1'b0, 2'b11, 32'd100, 32'd7, 1'b1);
      wait_done(1'b0, "divu_100_7");
      issue(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done(1'b0, "div_min");
      issue(1'b0, 2'b11, 32'h1234_5678, 32'h0000_9ABC, 1'b1);
      wait_done(1'b0, "b2b");
      issue(1'b0, 2'b10, 32'h8000_0000, 32'd0, 1'b1);
      wait_done(1'b0, "div_min_zero");

      for (int i = 0; i < 6; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         r_b  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
         issue(1'b0, r_op, r_a, r_b, 1'b1);
         wait_done(1'b0, "rand");
      end

      // flush mid-operation; stall and ignored MTHI while busy
      issue(1'b0, 2'b01, 32'd5, 32'd6, 1'b0);
      mf_req = 1'b1;
      #1;
      check_val("stall_mf_busy", 64'(stall32), 64'd1);
      mf_req = 1'b0;
      hi_we  = 1'b1;
      wdata  = 32'hDEAD_BEEF;
      #1;
      check_val("stall_mthi_busy", 64'(stall32), 64'd1);
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      check_val("mthi_ignored_busy", 64'(hi32), 64'(last_hi));
      repeat (7) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_val("flush_busy", 64'(busy32), 64'd0);
      check_val("flush_hi", 64'(hi32), 64'(last_hi));
      check_val("flush_lo", 64'(lo32), 64'(last_lo));
      mf_req = 1'b1;
      #1;
      check_val("stall_mf_idle", 64'(stall32), 64'd0);
      mf_req = 1'b0;
      repeat (40) @(posedge clk);
      #1;

      flush = 1'b1;
      issue(1'b0, 2'b01, 32'd5, 32'd6, 1'b0);
      flush = 1'b0;
      check_val("flush_drops_start", 64'(busy32), 64'd0);

      lo_we = 1'b1;
      wdata = 32'h0000_1234;
      @(posedge clk);
      #1;
      lo_we = 1'b0;
      check_val("mtlo_idle", 64'(lo32), 64'h1234);
      check_val("mtlo_hi_kept", 64'(hi32), 64'(last_hi));

      hi_we = 1'b1;
      wdata = 32'hAAAA_5555;
      issue(1'b0, 2'b01, 32'd3, 32'd4, 1'b1);
      hi_we = 1'b0;
      check_val("mthi_with_start", 64'(hi32), 64'hAAAA_5555);
      wait_done(1'b0, "after_mthi");

      // asynchronous reset in the middle of a divide
      issue(1'b0, 2'b10, 32'd1000, 32'd3, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("amid_rst_busy", 64'(busy32), 64'd0);
      check_val("amid_rst_done", 64'(done32), 64'd0);
      check_val("amid_rst_hi", 64'(hi32), 64'd0);
      check_val("amid_rst_lo", 64'(lo32), 64'd0);
      check_val("amid_rst_lo8", 64'(lo8), 64'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(1'b1, 2'b00, 32'h0000_00FD, 32'd7, 1'b1);
      wait_done(1'b1, "w8_mult");
      issue(1'b1, 2'b10, 32'h0000_00F9, 32'd2, 1'b1);
      wait_done(1'b1, "w8_div");
      issue(1'b1, 2'b10, 32'h0000_0080, 32'h0000_00FF, 1'b1);
      wait_done(1'b1, "w8_div_min");
      issue(1'b1, 2'b11, 32'd100, 32'd0, 1'b1);
      wait_done(1'b1, "w8_divu_zero");
      issue(1'b1, 2'b01, 32'h0000_00FF, 32'h0000_00FF, 1'b1);
      wait_done(1'b1, "w8_multu");
      for (int j = 0; j < 3; j++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         r_b  = $urandom;
         issue(1'b1, r_op, r_a, r_b, 1'b1);
         wait_done(1'b1, "w8_rand");
      end

      repeat (3) @(posedge clk);
      #1;
      check_val("q32_drained", 64'(q32.size()), 64'd0);
      check_val("q8_drained", 64'(q8.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the pipelined MIPS datapath, owning the HI/LO architectural registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, one bit per cycle, width set by parameter.
- Drives a stall request to the hazard logic while busy. Supports flush-abort and MTHI/MTLO/MFHI/MFLO access.

Parameters:
- WIDTH, 32: operand width in bits (≥4); HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1): iteration counter width.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  operation request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  abort the in-flight operation.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- mf_req  in  1  an MFHI/MFLO is in ID this cycle.
- busy  out  1  state != IDLE.
- stall  out  1  busy & (start | mf_req | hi_we | lo_we); combinational.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- div_zero  out  1  registered; set with done when a DIV/DIVU had b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, done=0, div_zero=0, counter=0, internal shift registers=0.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch op; latch |a| and |b| for signed ops (raw values for unsigned); latch the sign bits. Clear div_zero. Go to CALC, counter=0.
  - Otherwise stay in IDLE.
- CALC, edges E1..E(WIDTH):
  - Multiply: shift-add, one multiplier bit per edge; 2*WIDTH-bit unsigned product.
  - Divide: restoring, one quotient bit per edge; WIDTH-bit quotient and remainder.
  - counter increments each edge; when counter==WIDTH-1, go to FIX.
- FIX, edge E(WIDTH+1):
  - Apply sign correction, write hi/lo, set done=1 for exactly one cycle, return to IDLE.
  - Total latency: hi/lo/done visible after E(WIDTH+1). busy is high for cycles E0..E(WIDTH+1) exclusive of the final edge.
- Result mapping:
  - Multiply: {hi,lo} = product. MULT negates the 2*WIDTH-bit product when sign_a^sign_b.
  - Divide: lo = quotient, hi = remainder. DIV negates the quotient when sign_a^sign_b, and negates the remainder when sign_a. The remainder takes the sign of the dividend.
- Signed overflow: DIV of MIN by -1 yields lo=MIN (0x80000000 at WIDTH=32) and hi=0, with no flag. This falls out of the unsigned-magnitude datapath.
- Divide by zero (b==0): full normal latency. Result is lo = all ones, hi = a (the original, unconverted a), div_zero=1 with done. This holds for both DIV and DIVU.
- Back-to-back: a start in the done cycle is accepted, since the state is IDLE. A start while busy is not accepted; stall holds it in ID until IDLE.
- Flush:
  - flush=1 in CALC or FIX: go to IDLE at the next edge. hi/lo are unchanged, and done/div_zero are not asserted.
  - flush and start together in IDLE: flush wins and the start is dropped.
  - flush in IDLE with no start: no effect.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata at the edge.
  - If start and hi_we/lo_we are both asserted in IDLE, the write is applied and the operation is also launched; its later result overwrites HI/LO.
  - While busy, writes are ignored, and stall=1 makes ID hold the instruction.
- MFHI/MFLO: a read while busy raises stall. In IDLE, hi/lo are read directly, including in the done cycle, which shows the new values.
- Reset mid-operation: immediate return to IDLE with all registers at their reset values.
- All arithmetic is unsigned inside CALC. Width conversions are explicit. There is no overflow flag for multiply.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 33 edges: hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly 1 cycle, busy low in the same cycle.
- MULT a=-3 (0xFFFFFFFD) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7 b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100 b=0 → lo=0xFFFFFFFF, hi=100, div_zero=1 with done. A following DIVU 100/7 → lo=14, hi=2, div_zero=0.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. Issue back-to-back starts → the second is accepted in the done cycle, and the second result appears 33 edges later.
- Start MULTU 5*6 then flush at cycle 10 → busy drops next edge, hi/lo keep their prior values, no done. mf_req during busy → stall=1; MTLO 0x1234 in IDLE → lo=0x1234.
- Assert rst_n=0 mid-CALC → asynchronously state=IDLE, hi=lo=0, busy=0, done=0. Repeat one multiply and one divide case with WIDTH=8 to check parametrisation.
